// File: rtl/stream_input_port_rx_if.sv
// Handshake bundle between the extract stage, the operator and the BFT credit path
// for one stream input port receiver.
interface stream_input_port_rx_if #(
    parameter int PACKET_BITS  = 97,
    parameter int PAYLOAD_BITS = 32
);
    logic [PACKET_BITS-1:0]  stream_in;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [PACKET_BITS-1:0]  credit_pkt_out;
    logic                    credit_resend;

    modport master (
        output stream_in,
        output dout_ready,
        output credit_resend,
        input  dout,
        input  dout_valid,
        input  credit_pkt_out
    );

    modport slave (
        input  stream_in,
        input  dout_ready,
        input  credit_resend,
        output dout,
        output dout_valid,
        output credit_pkt_out
    );
endinterface

// File: rtl/stream_input_port_rx.sv
// Stream input port receiver: FWFT payload FIFO fed from the BFT, with credit packets
// returned to the source leaf in batches through a resend-protected output register.
module stream_input_port_rx #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int PAYLOAD_BITS  = 32,
    parameter int PORT_ID       = 2,
    parameter int ADDR_BITS     = 4,
    parameter int CREDIT_BATCH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    stream_input_port_rx_if.slave    bus,
    input  logic [NUM_LEAF_BITS-1:0] i_cfg_src_leaf,
    input  logic [NUM_PORT_BITS-1:0] i_cfg_src_port,
    output logic [ADDR_BITS:0]       o_fill_level,
    output logic                     o_overflow
);
    localparam int DEPTH    = 1 << ADDR_BITS;
    localparam int PORT_MSB = PACKET_BITS - 2 - NUM_LEAF_BITS;
    localparam int PF_BITS  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] BATCH_LAST = (ADDR_BITS+1)'(CREDIT_BATCH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0]    r_wr_ptr;
    logic [ADDR_BITS-1:0]    r_rd_ptr;
    logic [ADDR_BITS:0]      r_count;
    logic                    r_valid;
    logic                    r_overflow;
    logic [ADDR_BITS:0]      r_pop_cnt;
    logic [ADDR_BITS:0]      r_pending;
    logic [PACKET_BITS-1:0]  r_credit_pkt;
    state_t                  r_state;

    logic                    w_hit;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_batch;
    logic                    w_dec;
    logic [ADDR_BITS:0]      w_count_nxt;
    logic [ADDR_BITS:0]      w_pending_nxt;
    logic [PF_BITS-1:0]      w_credit_payload;
    logic [PACKET_BITS-1:0]  w_credit_pkt;
    logic [PACKET_BITS-1:0]  w_pkt_nxt;
    state_t                  w_state_nxt;

    // A full FIFO still takes a packet when the head leaves in the same cycle.
    assign w_hit   = bus.stream_in[PACKET_BITS-1] &&
                     (bus.stream_in[PORT_MSB -: NUM_PORT_BITS] == NUM_PORT_BITS'(PORT_ID));
    assign w_pop   = r_valid && bus.dout_ready;
    assign w_push  = w_hit && ((r_count != DEPTH_CNT) || w_pop);
    assign w_drop  = w_hit && !w_push;
    assign w_batch = w_pop && (r_pop_cnt == BATCH_LAST);
    assign w_dec   = (r_state == ST_SEND) && !bus.credit_resend;

    assign bus.dout       = r_mem[r_rd_ptr];
    assign bus.dout_valid = r_valid;
    assign bus.credit_pkt_out = r_credit_pkt;
    assign o_fill_level   = r_count;
    assign o_overflow     = r_overflow;

    // FIFO occupancy for the coming cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_BITS+1)'(1'b1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (ADDR_BITS+1)'(1'b1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Payload storage; pointer state lives in the control register block.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= bus.stream_in[PAYLOAD_BITS-1:0];
        end
    end

    // FIFO pointers, occupancy, valid flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1'b1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outstanding credits: a completed batch and an accepted packet may coincide.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_batch && !w_dec) begin
            w_pending_nxt = r_pending + (ADDR_BITS+1)'(1'b1);
        end else if (w_dec && !w_batch) begin
            w_pending_nxt = r_pending - (ADDR_BITS+1)'(1'b1);
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Pop batching and pending-credit bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_cnt <= '0;
            r_pending <= '0;
        end else begin
            if (w_batch) begin
                r_pop_cnt <= '0;
            end else if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + (ADDR_BITS+1)'(1'b1);
            end
            r_pending <= w_pending_nxt;
        end
    end

    // Credit packet image returned to the source leaf.
    always_comb begin
        w_credit_payload        = '0;
        w_credit_payload[19:16] = 4'(PORT_ID);
        w_credit_payload[15:0]  = 16'(CREDIT_BATCH);
        w_credit_pkt            = {1'b1, i_cfg_src_leaf, i_cfg_src_port, w_credit_payload};
    end

    // Credit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Credit FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != '0) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.credit_resend || (w_pending_nxt != '0)) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Credit FSM output: next value of the registered credit packet.
    always_comb begin
        w_pkt_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != '0) begin
                    w_pkt_nxt = w_credit_pkt;
                end else begin
                    w_pkt_nxt = '0;
                end
            end
            ST_SEND: begin
                if (bus.credit_resend) begin
                    w_pkt_nxt = r_credit_pkt;
                end else if (w_pending_nxt != '0) begin
                    w_pkt_nxt = w_credit_pkt;
                end else begin
                    w_pkt_nxt = '0;
                end
            end
            default: w_pkt_nxt = '0;
        endcase
    end

    // Registered credit packet toward the BFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_pkt <= '0;
        end else begin
            r_credit_pkt <= w_pkt_nxt;
        end
    end
endmodule

// File: tb/tb_stream_input_port_rx.sv
// Randomized and directed bench for stream_input_port_rx against a queue-based
// reference model of the FIFO and a credit-count model of the return path.
module tb_stream_input_port_rx;
    localparam int DEPTH = 16;
    localparam int BATCH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] cfg_leaf = 6'd5;
    logic [3:0] cfg_port = 4'd9;
    logic [4:0] fill;
    logic       ovf;

    stream_input_port_rx_if #(.PACKET_BITS(97), .PAYLOAD_BITS(32)) bus ();

    stream_input_port_rx #(
        .PACKET_BITS(97), .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4), .PAYLOAD_BITS(32),
        .PORT_ID(2), .ADDR_BITS(4), .CREDIT_BATCH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .i_cfg_src_leaf (cfg_leaf),
        .i_cfg_src_port (cfg_port),
        .o_fill_level   (fill),
        .o_overflow     (ovf)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_q [$];
    logic        m_ovf;
    int          m_pops;
    int          m_acc;
    logic [96:0] exp_credit;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [96:0] mk_pkt(input logic v, input logic [3:0] port, input logic [31:0] pl);
        logic [96:0] p;
        p         = '0;
        p[96]     = v;
        p[95:90]  = 6'($urandom);
        p[89:86]  = port;
        p[85:54]  = $urandom;
        p[53:32]  = 22'($urandom);
        p[31:0]   = pl;
        return p;
    endfunction

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic [96:0] pkt, input logic rdy, input logic rs);
        logic pre_nz;
        logic pop;
        logic hit;
        bus.stream_in     = pkt;
        bus.dout_ready    = rdy;
        bus.credit_resend = rs;
        @(negedge clk);
        pre_nz = (bus.credit_pkt_out != '0);
        pop    = (m_q.size() > 0) && rdy;
        hit    = pkt[96] && (pkt[89:86] == 4'd2);
        if (pop) begin
            void'(m_q.pop_front());
            m_pops++;
        end
        if (hit) begin
            if (m_q.size() < DEPTH) m_q.push_back(pkt[31:0]);
            else m_ovf = 1'b1;
        end
        if (pre_nz && !rs) m_acc++;
        @(posedge clk);
        #1;
        check("fill", fill, m_q.size());
        check("valid", bus.dout_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("dout", bus.dout, m_q[0]);
        check("overflow", ovf, m_ovf);
        if (bus.credit_pkt_out != '0) begin
            check("credit_pkt", bus.credit_pkt_out, exp_credit);
            check("credit_owed", (m_pops / BATCH) > m_acc, 1'b1);
        end else if (pre_nz && rs) begin
            check("credit_hold", bus.credit_pkt_out, exp_credit);
        end
    endtask

    task automatic do_reset(input logic rs);
        reset             = 1'b1;
        bus.stream_in     = '0;
        bus.dout_ready    = 1'b0;
        bus.credit_resend = rs;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_pops = 0;
        m_acc  = 0;
        check("rst_fill", fill, 5'd0);
        check("rst_valid", bus.dout_valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_credit", bus.credit_pkt_out, 97'd0);
    endtask

    task automatic wait_credit(input int max);
        int k;
        k = 0;
        while ((bus.credit_pkt_out == '0) && (k < max)) begin
            step('0, 1'b0, 1'b0);
            k++;
        end
        check("credit_timeout", bus.credit_pkt_out != '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [85:0] exp_pl;
        logic [3:0]  port;
        logic        rdy;
        int          acc0;
        exp_pl     = 86'h2_0004;
        exp_credit = {1'b1, 6'd5, 4'd9, exp_pl};
        reset             = 1'b1;
        bus.stream_in     = '0;
        bus.dout_ready    = 1'b0;
        bus.credit_resend = 1'b0;
        m_ovf = 1'b0; m_pops = 0; m_acc = 0;
        do_reset(1'b0);

        // Three packets, FWFT order with ready held high.
        step(mk_pkt(1'b1, 4'd2, 32'hA), 1'b1, 1'b0);
        check("t1_first", bus.dout, 32'hA);
        step(mk_pkt(1'b1, 4'd2, 32'hB), 1'b1, 1'b0);
        step(mk_pkt(1'b1, 4'd2, 32'hC), 1'b1, 1'b0);
        check("t1_third", bus.dout, 32'hC);
        step('0, 1'b1, 1'b0);

        // Foreign port, invalid, port 0: nothing enters.
        step(mk_pkt(1'b1, 4'd3, 32'h11), 1'b1, 1'b0);
        step(mk_pkt(1'b0, 4'd2, 32'h22), 1'b1, 1'b0);
        step(mk_pkt(1'b1, 4'd0, 32'h33), 1'b1, 1'b0);
        check("t2_fill", fill, 5'd0);

        // Overflow and full push+pop.
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) step(mk_pkt(1'b1, 4'd2, 32'd100 + 32'(i)), 1'b0, 1'b0);
        check("t3_fill", fill, 5'd16);
        check("t3_ovf", ovf, 1'b1);
        check("t3_head", bus.dout, 32'd100);
        step(mk_pkt(1'b1, 4'd2, 32'd200), 1'b1, 1'b0);
        check("t3_fill_pp", fill, 5'd16);
        check("t3_head2", bus.dout, 32'd101);

        // One batch of pops produces one credit packet.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) step(mk_pkt(1'b1, 4'd2, 32'(i)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
        wait_credit(10);
        check("t4_msb", bus.credit_pkt_out[96], 1'b1);
        check("t4_leaf", bus.credit_pkt_out[95:90], 6'd5);
        check("t4_port", bus.credit_pkt_out[89:86], 4'd9);
        check("t4_payload", bus.credit_pkt_out[85:0], exp_pl);
        step('0, 1'b0, 1'b0);
        check("t4_cleared", bus.credit_pkt_out, 97'd0);

        // Resend for three cycles holds the packet.
        for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
        wait_credit(10);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b0, 1'b1);
            check("t5_hold", bus.credit_pkt_out, exp_credit);
        end
        step('0, 1'b0, 1'b0);
        check("t5_cleared", bus.credit_pkt_out, 97'd0);

        // Two batches under resend drain back-to-back.
        for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        acc0 = m_acc;
        step('0, 1'b0, 1'b0);
        check("t6_second", bus.credit_pkt_out, exp_credit);
        step('0, 1'b0, 1'b0);
        check("t6_back2back", m_acc - acc0, 2);
        check("t6_cleared", bus.credit_pkt_out, 97'd0);

        // Reset while a credit is being driven.
        for (int i = 0; i < 6; i++) step(mk_pkt(1'b1, 4'd2, 32'(i)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
        wait_credit(10);
        do_reset(1'b1);

        // Random traffic: slow consumer first, then fast.
        for (int i = 0; i < 800; i++) begin
            rdy = (i < 400) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            case ($urandom % 6)
                0, 1, 2: port = 4'd2;
                3:       port = 4'd3;
                4:       port = 4'd0;
                default: port = 4'($urandom);
            endcase
            step(mk_pkt(($urandom % 5) != 0, port, $urandom), rdy, ($urandom % 10) < 3);
        end
        for (int i = 0; i < 40; i++) step('0, 1'b1, 1'b0);
        check("drain_credits", m_acc, m_pops / BATCH);
        check("drain_idle", bus.credit_pkt_out, 97'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
